// File: rtl/fp_div_seq.sv
// Multicycle IEEE-754 single-precision divider, z = a / b.
// Radix-2 restoring mantissa division, BITS_PER_CYCLE quotient bits per clock,
// valid/ready handshake on both sides, one operation in flight.
// Denormal operands are flushed to zero; status layout matches the FP multiplier.
module fp_div_seq #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  rnd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z,
    output logic [7:0]  status
);
    localparam int unsigned N   = 27 / BITS_PER_CYCLE;
    localparam int          Bpc = int'(BITS_PER_CYCLE);

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 3 ||
          BITS_PER_CYCLE == 9 || BITS_PER_CYCLE == 27)) begin : g_bad_bpc
        $error("fp_div_seq: BITS_PER_CYCLE must be 1, 3, 9 or 27");
    end

    typedef enum logic [1:0] {StIdle, StDiv, StRound, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, b_q;
    logic [2:0]  rnd_q;
    logic [4:0]  cnt_q, cnt_d;
    logic [24:0] rem_q, rem_d, rem_t;
    logic [26:0] quo_q, quo_d, quo_t;
    logic [31:0] z_q, z_d;
    logic [7:0]  status_q, status_d;
    logic        accept;

    assign accept = (state_q == StIdle) && in_valid;

    // State, operand, datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            rnd_q    <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            z_q      <= '0;
            status_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                rnd_q <= rnd;
            end
            if (state_q == StRound) begin
                z_q      <= z_d;
                status_q <= status_d;
            end
        end
    end

    // Next-state logic; DIV spends one load cycle then N iteration cycles.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StDiv;
            StDiv:   if (cnt_q == 5'(N)) state_d = StRound;
            StRound: state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        z         = z_q;
        status    = status_q;
    end

    // Restoring division: the remainder always stays below 2*Mb, so 25 bits suffice.
    always_comb begin
        cnt_d = (state_q == StDiv) ? cnt_q + 5'd1 : '0;
        rem_d = rem_q;
        quo_d = quo_q;
        rem_t = rem_q;
        quo_t = quo_q;
        if (state_q == StDiv) begin
            if (cnt_q == '0) begin
                rem_d = {2'b01, a_q[22:0]};
                quo_d = '0;
            end else begin
                for (int i = 0; i < Bpc; i++) begin
                    if (rem_t >= {2'b01, b_q[22:0]}) begin
                        rem_t = rem_t - {2'b01, b_q[22:0]};
                        quo_t = {quo_t[25:0], 1'b1};
                    end else begin
                        quo_t = {quo_t[25:0], 1'b0};
                    end
                    rem_t = {rem_t[23:0], 1'b0};
                end
                rem_d = rem_t;
                quo_d = quo_t;
            end
        end
    end

    logic              sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [23:0]       mant, mant_f;
    logic [24:0]       mant_r;
    logic              g, s, inc, rne, rtz, rup, rdn, rta, raw;
    logic signed [9:0] e_n, e_f;
    logic              ovf, unf, to_inf, to_min;
    logic              f_zero, f_inf, f_nan, f_tiny, f_huge, f_inx, f_dbz;

    // Normalise, round and classify the quotient; specials override the rounded value.
    always_comb begin
        sign   = a_q[31] ^ b_q[31];
        a_zero = (a_q[30:23] == 8'h00);
        b_zero = (b_q[30:23] == 8'h00);
        a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == '0);
        b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == '0);
        a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != '0);
        b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != '0);

        rtz = (rnd_q == 3'b001);
        rup = (rnd_q == 3'b010);
        rdn = (rnd_q == 3'b011);
        rta = (rnd_q == 3'b100);
        raw = (rnd_q == 3'b101);
        rne = !(rtz || rup || rdn || rta || raw);

        e_n = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]});
        if (quo_q[26]) begin
            mant = quo_q[26:3];
            g    = quo_q[2];
            s    = (|quo_q[1:0]) | (rem_q != '0);
            e_n  = e_n + 10'sd127;
        end else begin
            mant = quo_q[25:2];
            g    = quo_q[1];
            s    = quo_q[0] | (rem_q != '0);
            e_n  = e_n + 10'sd126;
        end

        inc = 1'b0;
        if (rne)      inc = g & (s | mant[0]);
        else if (rup) inc = ~sign & (g | s);
        else if (rdn) inc = sign & (g | s);
        else if (rta) inc = g;
        else if (raw) inc = g | s;

        mant_r = {1'b0, mant} + {24'd0, inc};
        if (mant_r[24]) begin
            mant_f = mant_r[24:1];
            e_f    = e_n + 10'sd1;
        end else begin
            mant_f = mant_r[23:0];
            e_f    = e_n;
        end

        ovf    = (e_f >= 10'sd255);
        unf    = (e_f <= 10'sd0);
        to_inf = rne || rta || raw || (rup && !sign) || (rdn && sign);
        to_min = raw || (rup && !sign) || (rdn && sign);

        f_nan  = 1'b0;
        f_dbz  = 1'b0;
        f_tiny = 1'b0;
        f_huge = 1'b0;
        f_inx  = g | s;
        if (ovf) begin
            f_huge = 1'b1;
            f_inx  = 1'b1;
            z_d    = to_inf ? {sign, 8'hFF, 23'd0} : {sign, 31'h7F7FFFFF};
        end else if (unf) begin
            f_tiny = 1'b1;
            f_inx  = 1'b1;
            z_d    = to_min ? {sign, 8'h01, 23'd0} : {sign, 31'd0};
        end else begin
            z_d = {sign, e_f[7:0], mant_f[22:0]};
        end

        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            z_d   = 32'h7FC00000;
            f_nan = 1'b1;
            f_inx = 1'b0;
            f_tiny = 1'b0;
            f_huge = 1'b0;
        end else if (a_inf || b_zero) begin
            z_d   = {sign, 8'hFF, 23'd0};
            f_dbz = !a_inf;
            f_inx = 1'b0;
            f_tiny = 1'b0;
            f_huge = 1'b0;
        end else if (a_zero || b_inf) begin
            z_d   = {sign, 31'd0};
            f_inx = 1'b0;
            f_tiny = 1'b0;
            f_huge = 1'b0;
        end

        f_zero   = (z_d[30:0] == 31'd0);
        f_inf    = (z_d[30:0] == 31'h7F800000);
        status_d = {1'b0, f_dbz, f_inx, f_huge, f_tiny, f_nan, f_inf, f_zero};
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: a 1-bit/cycle and a 3-bit/cycle instance share the same
// stimulus; each is checked for value, status and latency.
module tb_fp_div_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [31:0] a, b;
    logic [2:0]  rnd;
    logic        in_ready1, out_valid1, in_ready3, out_valid3;
    logic [31:0] z1, z3;
    logic [7:0]  st1, st3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fp_div_seq #(.BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .rnd(rnd), .out_valid(out_valid1), .out_ready(out_ready),
        .z(z1), .status(st1)
    );

    fp_div_seq #(.BITS_PER_CYCLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
        .a(a), .b(b), .rnd(rnd), .out_valid(out_valid3), .out_ready(out_ready),
        .z(z3), .status(st3)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rnd;
        logic [31:0] z;
        logic [7:0]  st;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One operation through both instances with out_ready held high.
    task automatic run_op(input string name, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [2:0] ir, input logic [31:0] ez, input logic [7:0] es);
        int          lat1, lat3;
        logic [31:0] gz1, gz3;
        logic [7:0]  gs1, gs3;
        logic        busy1, busy3;
        lat1 = 0; lat3 = 0; gz1 = '0; gz3 = '0; gs1 = '0; gs3 = '0;
        busy1 = 1'b1; busy3 = 1'b1;
        out_ready = 1'b1;
        a = ia; b = ib; rnd = ir; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (lat1 == 0) begin
                if (out_valid1) begin lat1 = k; gz1 = z1; gs1 = st1; end
                else if (in_ready1) busy1 = 1'b0;
            end
            if (lat3 == 0) begin
                if (out_valid3) begin lat3 = k; gz3 = z3; gs3 = st3; end
                else if (in_ready3) busy3 = 1'b0;
            end
        end
        chk({name, " z bpc1"}, gz1, ez);
        chk({name, " status bpc1"}, {24'd0, gs1}, {24'd0, es});
        chk({name, " latency bpc1"}, 32'(lat1), 32'd29);
        chk({name, " in_ready busy bpc1"}, {31'd0, busy1}, 32'd1);
        chk({name, " z bpc3"}, gz3, ez);
        chk({name, " status bpc3"}, {24'd0, gs3}, {24'd0, es});
        chk({name, " latency bpc3"}, 32'(lat3), 32'd11);
        chk({name, " in_ready busy bpc3"}, {31'd0, busy3}, 32'd1);
    endtask

    vec_t vecs[11];

    initial begin
        int           waited;
        logic [31:0]  hz;
        logic [7:0]   hs;
        logic         stable;

        vecs[0]  = '{"6/2 rne",       32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 8'h00};
        vecs[1]  = '{"1/3 rne",       32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 8'h20};
        vecs[2]  = '{"1/3 rtz",       32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 8'h20};
        vecs[3]  = '{"-1/3 rup",      32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAA, 8'h20};
        vecs[4]  = '{"-1/3 rdn",      32'hBF800000, 32'h40400000, 3'b011, 32'hBEAAAAAB, 8'h20};
        vecs[5]  = '{"1/0",           32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 8'h42};
        vecs[6]  = '{"0/0",           32'h00000000, 32'h00000000, 3'b000, 32'h7FC00000, 8'h04};
        vecs[7]  = '{"-1/inf",        32'hBF800000, 32'h7F800000, 3'b000, 32'h80000000, 8'h01};
        vecs[8]  = '{"max/min rne",   32'h7F7FFFFF, 32'h00800000, 3'b000, 32'h7F800000, 8'h32};
        vecs[9]  = '{"max/min rtz",   32'h7F7FFFFF, 32'h00800000, 3'b001, 32'h7F7FFFFF, 8'h30};
        vecs[10] = '{"min/max rne",   32'h00800000, 32'h7F7FFFFF, 3'b000, 32'h00000000, 8'h29};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; rnd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", {30'd0, in_ready1, in_ready3}, 32'd3);
        chk("reset out_valid", {30'd0, out_valid1, out_valid3}, 32'd0);
        chk("reset z", z1 | z3, 32'd0);
        chk("reset status", {16'd0, st1, st3}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].rnd, vecs[i].z, vecs[i].st);
        end

        // Backpressure: result held while out_ready is low, new operand waits.
        out_ready = 1'b0;
        a = 32'h40C00000; b = 32'h40000000; rnd = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid1 && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("bp out_valid reached", {31'd0, out_valid1}, 32'd1);
        hz = z1; hs = st1;
        chk("bp z", hz, 32'h40400000);
        a = 32'h3F800000; b = 32'h40400000; rnd = 3'b000; in_valid = 1'b1;
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (!out_valid1 || z1 !== hz || st1 !== hs || in_ready1) stable = 1'b0;
            if (!out_valid3 || z3 !== 32'h40400000 || in_ready3) stable = 1'b0;
        end
        chk("bp hold stable", {31'd0, stable}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp handshake out_valid", {30'd0, out_valid1, out_valid3}, 32'd0);
        chk("bp handshake in_ready", {30'd0, in_ready1, in_ready3}, 32'd3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp accepted next", {30'd0, in_ready1, in_ready3}, 32'd0);
        waited = 0;
        while (!out_valid1 && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("bp second z", z1, 32'h3EAAAAAB);
        @(posedge clk); #1;

        // Reset in the middle of DIV.
        a = 32'h3F800000; b = 32'h40400000; rnd = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midop reset in_ready", {30'd0, in_ready1, in_ready3}, 32'd3);
        chk("midop reset out_valid", {30'd0, out_valid1, out_valid3}, 32'd0);
        chk("midop reset z", z1 | z3, 32'd0);
        chk("midop reset status", {16'd0, st1, st3}, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("6/2 after reset", 32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
